lowx_arbiter: RTL and testbench
===============================

# lowx_arbiter

Two-requester arbiter and sequencer for the shared lower-level memory port (ilowX). Requester 0 is the instruction cache refill path, requester 1 the data-side/uncached fetch path; the block grants one requester at a time, forwards its 32-bit address and uncached flag to ilowX, and returns the 128-bit block response to the granted requester. It sits between the caches and the lower memory, with at most one outstanding lower-level transaction.

## Interface
- `XLEN`, 32, address width
- `BLK_SIZE`, 128, block/response width
- `TIMEOUT_CYC`, 255, response watchdog limit in cycles (used only with the macro below); range 1..65535
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `req_valid_i`  in  2  per-requester request valid
- `req_ready_o`  out  2  per-requester request accept pulse
- `req_addr_i`  in  2×XLEN  per-requester address
- `req_uncached_i`  in  2  per-requester uncached flag
- `res_valid_o`  out  2  per-requester response valid
- `res_ready_i`  in  2  per-requester response ready
- `res_blk_o`  out  BLK_SIZE  response block, shared, valid only with a `res_valid_o` bit
- `res_err_o`  out  1  response error, qualifies `res_blk_o`
- `lowx_req_valid_o`  out  1  ilowX request valid
- `lowx_req_ready_i`  in  1  ilowX request ready
- `lowx_req_addr_o`  out  XLEN  ilowX address
- `lowx_req_uncached_o`  out  1  ilowX uncached flag
- `lowx_res_valid_i`  in  1  ilowX response valid
- `lowx_res_ready_o`  out  1  ilowX response ready
- `lowx_res_blk_i`  in  BLK_SIZE  ilowX response block

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid_i` is set, pick the grant `g`:
  - Only one requester valid: grant that one.
  - Both valid: grant the priority pointer `prio`.
  - On grant: pulse `req_ready_o[g]` combinationally this cycle, latch addr, uncached and `g`, then go to ISSUE.
- ISSUE: `lowx_req_valid_o`=1 with the latched addr/uncached, held stable until `lowx_req_ready_i`. Then go to WAIT.
- WAIT: `lowx_res_ready_o`=1. On `lowx_res_valid_i`, latch `lowx_res_blk_i`, clear the error flag, go to RESP.
- RESP: `res_valid_o[g]`=1, drive the latched blk and error. On `res_ready_i[g]`, set `prio` ← `~g` and go to IDLE.
- The non-granted requester sees `req_ready_o`=0 and `res_valid_o`=0 throughout. Its valid may stay high; it is served next.
- A requester must hold valid/addr stable until its ready pulse. The arbiter never reads addr after the grant cycle.
- Reset values:
  - State IDLE, `prio`=0.
  - All outputs 0: `req_ready_o`, `res_valid_o`, `lowx_req_valid_o`, `lowx_res_ready_o`, `res_err_o`; `res_blk_o` and `lowx_req_addr_o` are 0.
- Reset asserted in any state aborts the transaction in the next cycle. The lower level is expected to be reset together.

## Timing
- Grant in cycle T → `lowx_req_valid_o` high from T+1.
- ISSUE with `lowx_req_ready_i`=1 at T+1 → WAIT at T+2.
- `lowx_res_valid_i` handshake in cycle R → `res_valid_o[g]` high at R+1.
- Minimum request-to-response latency is 3 cycles plus lower-level latency.
- `res_ready_i` handshake in cycle S → IDLE at S+1, so the next grant comes at S+1 at the earliest. One dead cycle between transactions is not allowed beyond this.
- `lowx_res_valid_i` outside WAIT is ignored. `res_ready_i` outside RESP, or on the non-granted index, is ignored.

## Configuration
- `LOWX_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYC` without `lowx_res_valid_i`: go to RESP with blk=0 and `res_err_o`=1, and set `lowx_res_ready_o`=0 from then on.
  - A response arriving in the same cycle as expiry wins (no error).
- Undefined: no counter; WAIT lasts indefinitely; `res_err_o` is tied to 0.

## Test plan
- Single request, req0 addr 0x0000_1000, uncached=0, lowX ready immediately, response blk 0xDEADBEEF… after 4 cycles → `req_ready_o`=2'b01 at T, `lowx_req_addr_o`=0x1000 at T+1, `res_valid_o`=2'b01 with matching blk one cycle after the lowX response, err=0.
- Both valid out of reset (req0 0x100, req1 0x200) → req0 served first; after its RESP handshake, req1 is granted in the next cycle with addr 0x200. Repeat with both still valid → order alternates 0,1,0,1.
- lowX backpressure: `lowx_req_ready_i` low for 5 cycles → addr/uncached/valid stable all 5 cycles, single handshake, no duplicate issue.
- Response backpressure: `res_ready_i[g]` low for 3 cycles → `res_valid_o`/blk held; a new req_valid on the other port is not granted until the handshake.
- Reset asserted in WAIT → next cycle all outputs 0, `prio`=0; a later lowX response is ignored.
- With `LOWX_ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=8, no lowX response → `res_valid_o[g]`=1, `res_err_o`=1, blk=0, 8 cycles after WAIT entry. Without the macro → still waiting after 1000 cycles.

Source files
------------

// File: rtl/lowx_arbiter.sv
// lowx_arbiter: two-requester arbiter/sequencer in front of the shared ilowX memory port.
// Optional response watchdog is compiled in when LOWX_ARB_TIMEOUT_EN is defined.
module lowx_arbiter #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BLK_SIZE    = 128,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [2*XLEN-1:0]     req_addr_i,
    input  logic [1:0]            req_uncached_i,
    output logic [1:0]            res_valid_o,
    input  logic [1:0]            res_ready_i,
    output logic [BLK_SIZE-1:0]   res_blk_o,
    output logic                  res_err_o,
    output logic                  lowx_req_valid_o,
    input  logic                  lowx_req_ready_i,
    output logic [XLEN-1:0]       lowx_req_addr_o,
    output logic                  lowx_req_uncached_o,
    input  logic                  lowx_res_valid_i,
    output logic                  lowx_res_ready_o,
    input  logic [BLK_SIZE-1:0]   lowx_res_blk_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("lowx_arbiter: TIMEOUT_CYC must be in 1..65535");
    end

    state_t              state_q;
    state_t              state_nxt;
    logic                prio_q;
    logic                gnt_q;
    logic                grant_vld;
    logic                grant_idx;
    logic [XLEN-1:0]     addr_q;
    logic                unc_q;
    logic [BLK_SIZE-1:0] blk_q;

`ifdef LOWX_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt_q;
    logic        tmo_hit;
    logic        err_q;
`endif

    // Next-state, grant selection and the combinational accept pulse
    always_comb begin
        state_nxt   = state_q;
        grant_vld   = 1'b0;
        grant_idx   = prio_q;
        req_ready_o = 2'b00;
`ifdef LOWX_ARB_TIMEOUT_EN
        tmo_hit     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rst_i && (req_valid_i != 2'b00)) begin
                    grant_vld = 1'b1;
                    if (req_valid_i == 2'b01) begin
                        grant_idx = 1'b0;
                    end else if (req_valid_i == 2'b10) begin
                        grant_idx = 1'b1;
                    end
                    req_ready_o[grant_idx] = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (lowx_req_ready_i) state_nxt = WAIT;
            end
            WAIT: begin
                if (lowx_res_valid_i) begin
                    state_nxt = RESP;
`ifdef LOWX_ARB_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = RESP;
`endif
                end
            end
            RESP: begin
                if (res_ready_i[gnt_q]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            unc_q   <= 1'b0;
            blk_q   <= '0;
`ifdef LOWX_ARB_TIMEOUT_EN
            tmo_cnt_q <= 16'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            if (grant_vld) begin
                gnt_q  <= grant_idx;
                addr_q <= grant_idx ? req_addr_i[2*XLEN-1:XLEN] : req_addr_i[XLEN-1:0];
                unc_q  <= req_uncached_i[grant_idx];
            end
            if (state_q == WAIT && lowx_res_valid_i) begin
                blk_q <= lowx_res_blk_i;
`ifdef LOWX_ARB_TIMEOUT_EN
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                blk_q <= '0;
                err_q <= 1'b1;
`endif
            end
            if (state_q == RESP && res_ready_i[gnt_q]) prio_q <= ~gnt_q;
`ifdef LOWX_ARB_TIMEOUT_EN
            // Counter sits at zero outside WAIT, so it is fresh on every WAIT entry
            tmo_cnt_q <= (state_q == WAIT) ? tmo_cnt_q + 16'd1 : 16'd0;
`endif
        end
    end

    assign lowx_req_valid_o    = (state_q == ISSUE);
    assign lowx_req_addr_o     = addr_q;
    assign lowx_req_uncached_o = unc_q;
    assign lowx_res_ready_o    = (state_q == WAIT);
    assign res_valid_o         = (state_q != RESP) ? 2'b00 : (gnt_q ? 2'b10 : 2'b01);
    assign res_blk_o           = blk_q;
`ifdef LOWX_ARB_TIMEOUT_EN
    assign res_err_o           = err_q;
`else
    assign res_err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_lowx_arbiter.sv
// tb_lowx_arbiter: scoreboard bench for lowx_arbiter with a behavioural lowX/requester model.
// Define LOWX_ARB_TIMEOUT_EN for both files to exercise the watchdog build.
module tb_lowx_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BLK  = 128;
`ifdef LOWX_ARB_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic              clk = 1'b0;
    logic              rst_i;
    logic [1:0]        req_valid_i;
    logic [1:0]        req_ready_o;
    logic [2*XLEN-1:0] req_addr_i;
    logic [1:0]        req_uncached_i;
    logic [1:0]        res_valid_o;
    logic [1:0]        res_ready_i;
    logic [BLK-1:0]    res_blk_o;
    logic              res_err_o;
    logic              lowx_req_valid_o;
    logic              lowx_req_ready_i;
    logic [XLEN-1:0]   lowx_req_addr_o;
    logic              lowx_req_uncached_o;
    logic              lowx_res_valid_i;
    logic              lowx_res_ready_o;
    logic [BLK-1:0]    lowx_res_blk_i;

    lowx_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_uncached_i(req_uncached_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_blk_o(res_blk_o), .res_err_o(res_err_o),
        .lowx_req_valid_o(lowx_req_valid_o), .lowx_req_ready_i(lowx_req_ready_i),
        .lowx_req_addr_o(lowx_req_addr_o), .lowx_req_uncached_o(lowx_req_uncached_o),
        .lowx_res_valid_i(lowx_res_valid_i), .lowx_res_ready_o(lowx_res_ready_o),
        .lowx_res_blk_i(lowx_res_blk_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          idx;
        logic [31:0] addr;
        bit          unc;
        logic [127:0] blk;
        bit          err;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];
    exp_t cur;

    int checks = 0;
    int failures = 0;
    int cyc_no = 0;
    int issues = 0;
    int wait_start = 0;
    int resp_at = 0;
    bit resp_seen = 0;
    bit exp_issue = 0, exp_resp = 0, exp_regrant = 0;
    int lx_stall = 0, lx_lat = 0, lx_cnt = 0, st_cnt = 0;
    bit lx_en = 1, lx_pend = 0, lx_force = 0;
    int rr_stall = 0, rr_cnt = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    function automatic logic [127:0] blk_of(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, 32'hDEADBEEF, ~a, a};
    endfunction

    function automatic logic [1:0] onehot(input bit i);
        return i ? 2'b10 : 2'b01;
    endfunction

    task automatic request(input bit idx, input logic [31:0] addr, input bit unc, input bit tmo);
        exp_t e;
        e.idx = idx; e.addr = addr; e.unc = unc;
        e.blk = tmo ? 128'd0 : blk_of(addr);
        e.err = tmo;
        gq.push_back(e);
        rq.push_back(e);
        req_valid_i[idx] = 1'b1;
        req_uncached_i[idx] = unc;
        if (idx) req_addr_i[63:32] = addr;
        else     req_addr_i[31:0]  = addr;
    endtask

    // One clock: sample and score at negedge, then drive the models just after posedge
    task automatic cyc();
        logic [1:0] clr;
        clr = 2'b00;
        @(negedge clk);
        cyc_no++;
        if (exp_issue) check("issue_lat", 128'(lowx_req_valid_o), 128'd1);
        if (exp_resp)  check("resp_lat", 128'(|res_valid_o), 128'd1);
        if (exp_regrant && req_valid_i != 2'b00) check("regrant_lat", 128'(|req_ready_o), 128'd1);
        exp_issue = 0; exp_resp = 0; exp_regrant = 0;
        if (|req_ready_o) begin
            if (gq.size() == 0) check("grant_unexp", 128'(req_ready_o), 128'd0);
            else begin
                cur = gq.pop_front();
                check("grant", 128'(req_ready_o), 128'(onehot(cur.idx)));
            end
            clr = req_ready_o; exp_issue = 1; issues = 0; lx_pend = 0;
        end
        if (lowx_req_valid_o) begin
            check("lowx_addr", 128'(lowx_req_addr_o), 128'(cur.addr));
            check("lowx_unc", 128'(lowx_req_uncached_o), 128'(cur.unc));
            if (lowx_req_ready_i) begin
                issues++; lx_pend = 1; lx_cnt = 0; wait_start = cyc_no + 1;
            end
        end
        if (lowx_res_valid_i && lowx_res_ready_o) begin
            lx_pend = 0; exp_resp = 1;
        end
        if (|res_valid_o) begin
            if (rq.size() == 0) check("resp_unexp", 128'(res_valid_o), 128'd0);
            else begin
                if (!resp_seen) begin resp_seen = 1; resp_at = cyc_no; end
                check("res_valid", 128'(res_valid_o), 128'(onehot(rq[0].idx)));
                check("res_blk", res_blk_o, rq[0].blk);
                check("res_err", 128'(res_err_o), 128'(rq[0].err));
                check("no_gnt_in_resp", 128'(req_ready_o), 128'd0);
                if ((res_valid_o & res_ready_i) != 2'b00) begin
                    if (!rq[0].err) check("issue_cnt", 128'(issues), 128'd1);
                    void'(rq.pop_front());
                    exp_regrant = 1; resp_seen = 0;
                end
            end
        end
        @(posedge clk); #1;
        req_valid_i = req_valid_i & ~clr;
        if (lowx_req_valid_o) begin
            lowx_req_ready_i = (st_cnt >= lx_stall);
            st_cnt = lowx_req_ready_i ? 0 : st_cnt + 1;
        end else begin
            lowx_req_ready_i = 1'b0; st_cnt = 0;
        end
        lowx_res_valid_i = 1'b0;
        if (lx_force) begin
            lowx_res_valid_i = 1'b1; lowx_res_blk_i = {4{$urandom}};
        end else if (lx_pend && lx_en) begin
            if (lx_cnt == lx_lat) begin
                lowx_res_valid_i = 1'b1; lowx_res_blk_i = blk_of(cur.addr);
            end
            lx_cnt++;
        end
        res_ready_i = 2'b00;
        if (|res_valid_o && rq.size() != 0) begin
            // While stalling, the other index asserts ready and must be ignored
            if (rr_cnt >= rr_stall) begin res_ready_i = onehot(rq[0].idx); rr_cnt = 0; end
            else begin res_ready_i = ~onehot(rq[0].idx); rr_cnt++; end
        end else rr_cnt = 0;
    endtask

    task automatic wait_done(input int n, input int limit);
        int k;
        k = 0;
        while (rq.size() > n && k < limit) begin cyc(); k++; end
        check("done", 128'(rq.size()), 128'(n));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_valid_i = 2'b00; res_ready_i = 2'b00;
        lowx_req_ready_i = 1'b0; lowx_res_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        gq.delete(); rq.delete();
        lx_pend = 0; lx_force = 0; lx_cnt = 0; st_cnt = 0; rr_cnt = 0;
        exp_issue = 0; exp_resp = 0; exp_regrant = 0; resp_seen = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_i = 1'b1; req_valid_i = 2'b00; req_addr_i = '0; req_uncached_i = 2'b00;
        res_ready_i = 2'b00; lowx_req_ready_i = 1'b0; lowx_res_valid_i = 1'b0; lowx_res_blk_i = '0;
        do_reset();
        @(negedge clk);
        check("rst_outs", {res_blk_o, lowx_req_addr_o, req_ready_o, res_valid_o,
                           lowx_req_valid_o, lowx_res_ready_o, res_err_o}, '0);
        @(posedge clk); #1;

        // Single request with a 4-cycle lowX latency
        lx_lat = 4;
        request(0, 32'h0000_1000, 0, 0);
        wait_done(0, 50);

        // Both valid out of reset, then keep both busy: order 0,1,0,1
        do_reset();
        lx_lat = 1;
        request(0, 32'h100, 0, 0);
        request(1, 32'h200, 1, 0);
        wait_done(1, 50);
        request(0, 32'h300, 0, 0);
        wait_done(1, 50);
        request(1, 32'h400, 0, 0);
        wait_done(0, 100);

        // lowX request backpressure for 5 cycles
        lx_stall = 5;
        request(1, 32'h0000_2040, 1, 0);
        wait_done(0, 50);
        lx_stall = 0;

        // Response backpressure, other port requests during RESP
        rr_stall = 3;
        request(0, 32'h3000, 0, 0);
        k = 0;
        while (!(|res_valid_o) && k < 50) begin cyc(); k++; end
        check("resp_reached", 128'(res_valid_o), 128'b01);
        request(1, 32'h3100, 1, 0);
        wait_done(0, 50);
        rr_stall = 0;

        // Reset in WAIT after prio has moved to 1
        lx_lat = 0;
        request(0, 32'h5000, 0, 0);
        wait_done(0, 50);
        lx_lat = 20;
        request(0, 32'h5100, 1, 0);
        k = 0;
        while (!lowx_res_ready_o && k < 20) begin cyc(); k++; end
        check("in_wait", 128'(lowx_res_ready_o), 128'd1);
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_wait", {res_blk_o, lowx_req_addr_o, req_ready_o, res_valid_o,
                              lowx_req_valid_o, lowx_res_ready_o, res_err_o}, '0);
        @(posedge clk); #1;
        do_reset();
        lx_force = 1;
        repeat (3) begin
            cyc();
            check("ign_lowx", 128'({res_valid_o, lowx_res_ready_o}), 128'd0);
        end
        lx_force = 0;
        lx_lat = 2;
        request(0, 32'h6000, 0, 0);
        request(1, 32'h6100, 0, 0);
        wait_done(0, 100);

`ifdef LOWX_ARB_TIMEOUT_EN
        // Watchdog expiry, then a response landing exactly on the expiry cycle
        lx_en = 0;
        request(1, 32'h7000, 0, 1);
        wait_done(0, 60);
        check("tmo_lat", 128'(resp_at - wait_start), 128'(TMO));
        lx_en = 1;
        lx_lat = TMO - 1;
        request(0, 32'h7100, 0, 0);
        wait_done(0, 60);
`else
        // No watchdog: WAIT persists indefinitely
        lx_en = 0;
        request(1, 32'h7000, 0, 0);
        repeat (1000) cyc();
        check("still_wait", 128'({lowx_res_ready_o, res_valid_o, res_err_o}), 128'b1000);
        lx_en = 1;
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
